// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divide unit.
// Operation and FSM state encodings used by RTL and benches.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle of the divide unit.
// master drives requests, slave is the divider.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [1:0]       op_sel;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, flush, op_sel, operand_a, operand_b,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, op_sel, operand_a, operand_b,
        output busy, done, result
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// quo_i carries the remaining dividend bits; quotient bits shift in at the LSB.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        diff    = shifted - {1'b0, div_i};
        // MSB set means the trial subtraction went negative: restore
        rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], ~diff[WIDTH]};
    end
endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned divider, one quotient bit per cycle.
// Divide-by-zero and signed overflow complete without iterating.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst_n,
    div_unit_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_CALC = CALC;
    localparam logic [1:0] S_DONE = DONE;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             is_rem_q, is_rem_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             div_zero;
    logic             ovf;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        sgn      = ~bus.op_sel[0];
        a_neg    = sgn & bus.operand_a[WIDTH-1];
        b_neg    = sgn & bus.operand_b[WIDTH-1];
        a_abs    = a_neg ? -bus.operand_a : bus.operand_a;
        b_abs    = b_neg ? -bus.operand_b : bus.operand_b;
        div_zero = (bus.operand_b == '0);
        ovf      = sgn && (bus.operand_a == MOST_NEG)
                       && (bus.operand_b == '1);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        is_rem_d = is_rem_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    is_rem_d = bus.op_sel[1];
                    if (div_zero) begin
                        result_d = bus.op_sel[1] ? bus.operand_a : '1;
                        state_d  = S_DONE;
                    end else if (ovf) begin
                        result_d = bus.op_sel[1] ? '0 : bus.operand_a;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = CW'(WIDTH - 1);
                        rem_d   = '0;
                        quo_d   = a_abs;
                        dvs_d   = b_abs;
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                    end
                end
            end
            S_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    if (is_rem_q)
                        result_d = r_neg_q ? -step_rem : step_rem;
                    else
                        result_d = q_neg_q ? -step_quo : step_quo;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything except reset and keeps the old result
        if (bus.flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            is_rem_q <= is_rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit (WIDTH=32).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           cyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one request, return result, cycle index of done
    // (1 = right after the accepting edge) and busy|done one cycle later.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output logic [W-1:0] res,
                          output int cyc, output logic tail);
        bus.op_sel    = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.operand_a = 32'hDEAD_BEEF;
        bus.operand_b = '0;
        bus.op_sel    = 2'b11;
        cyc = -1;
        for (int k = 1; k <= 80; k++) begin
            if (bus.done) begin
                cyc = k;
                break;
            end
            tick();
        end
        res = bus.result;
        tick();
        tail = bus.done | bus.busy;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.flush     = 1'b0;
        bus.op_sel    = 2'b00;
        bus.operand_a = '0;
        bus.operand_b = '0;
        repeat (3) tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b exp=0", bus.done);
        end
        checks++;
        if (bus.result !== 32'h0) begin
            failures++;
            $display("FAIL reset_result got=%h exp=0", bus.result);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_unsigned();
        vec_t v[5] = '{
            '{DIVU, 32'd100, 32'd7, 32'd14, 33},
            '{REMU, 32'd100, 32'd7, 32'd2, 33},
            '{DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33},
            '{REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33},
            '{DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33}
        };
        logic [W-1:0] res;
        int           cyc;
        logic         tail;
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, res, cyc, tail);
            checks++;
            if (res !== v[i].exp || cyc != v[i].cyc || tail !== 1'b0) begin
                failures++;
                $display("FAIL unsigned[%0d] got=%h cyc=%0d tail=%b exp=%h cyc=%0d tail=0",
                         i, res, cyc, tail, v[i].exp, v[i].cyc);
            end
        end
    endtask

    task automatic test_signed();
        vec_t v[7] = '{
            '{DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33},
            '{REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33},
            '{DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33},
            '{REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33},
            '{DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 33},
            '{REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33},
            '{DIV, 32'h8000_0000, 32'd1, 32'h8000_0000, 33}
        };
        logic [W-1:0] res;
        int           cyc;
        logic         tail;
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, res, cyc, tail);
            checks++;
            if (res !== v[i].exp || cyc != v[i].cyc || tail !== 1'b0) begin
                failures++;
                $display("FAIL signed[%0d] got=%h cyc=%0d tail=%b exp=%h cyc=%0d tail=0",
                         i, res, cyc, tail, v[i].exp, v[i].cyc);
            end
        end
    endtask

    task automatic test_div_zero();
        vec_t v[4] = '{
            '{DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1},
            '{REMU, 32'd5, 32'd0, 32'd5, 1},
            '{REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1},
            '{DIVU, 32'd0, 32'd0, 32'hFFFF_FFFF, 1}
        };
        logic [W-1:0] res;
        int           cyc;
        logic         tail;
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, res, cyc, tail);
            checks++;
            if (res !== v[i].exp || cyc != v[i].cyc || tail !== 1'b0) begin
                failures++;
                $display("FAIL div_zero[%0d] got=%h cyc=%0d tail=%b exp=%h cyc=%0d tail=0",
                         i, res, cyc, tail, v[i].exp, v[i].cyc);
            end
        end
    endtask

    task automatic test_overflow();
        vec_t v[3] = '{
            '{DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
            '{REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1},
            '{REM, 32'h8000_0000, 32'd2, 32'h0, 33}
        };
        logic [W-1:0] res;
        int           cyc;
        logic         tail;
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, res, cyc, tail);
            checks++;
            if (res !== v[i].exp || cyc != v[i].cyc || tail !== 1'b0) begin
                failures++;
                $display("FAIL overflow[%0d] got=%h cyc=%0d tail=%b exp=%h cyc=%0d tail=0",
                         i, res, cyc, tail, v[i].exp, v[i].cyc);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int cyc;
        bus.op_sel    = DIVU;
        bus.operand_a = 32'd1000;
        bus.operand_b = 32'd10;
        bus.start     = 1'b1;
        tick();
        bus.operand_a = 32'd5;
        bus.operand_b = 32'd1;
        bus.op_sel    = DIV;
        cyc = -1;
        for (int k = 1; k <= 80; k++) begin
            if (bus.done) begin
                cyc = k;
                break;
            end
            bus.start = (k >= 3 && k <= 5);
            tick();
        end
        checks++;
        if (bus.result !== 32'd100 || cyc != 33) begin
            failures++;
            $display("FAIL busy_ignore got=%h cyc=%0d exp=%h cyc=33",
                     bus.result, cyc, 32'd100);
        end
        // a start presented only during the DONE cycle must be dropped
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL done_ignore busy=%b done=%b exp busy=0 done=0",
                     bus.busy, bus.done);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.result !== 32'd100) begin
            failures++;
            $display("FAIL no_queue busy=%b res=%h exp busy=0 res=%h",
                     bus.busy, bus.result, 32'd100);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] res;
        int           cyc;
        logic         tail;
        bus.op_sel    = DIVU;
        bus.operand_a = 32'd100;
        bus.operand_b = 32'd7;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = -1;
        for (int k = 1; k <= 80; k++) begin
            if (bus.done) begin
                cyc = k;
                break;
            end
            tick();
        end
        checks++;
        if (cyc != 33 || bus.result !== 32'd14) begin
            failures++;
            $display("FAIL b2b_first got=%h cyc=%0d exp=%h cyc=33",
                     bus.result, cyc, 32'd14);
        end
        // held start: dropped on the DONE edge, taken on the first IDLE edge
        bus.op_sel    = DIVU;
        bus.operand_a = 32'd9;
        bus.operand_b = 32'd3;
        bus.start     = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle busy=%b exp=0", bus.busy);
        end
        run_op(DIVU, 32'd9, 32'd3, res, cyc, tail);
        checks++;
        if (res !== 32'd3 || cyc != 33 || tail !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second got=%h cyc=%0d tail=%b exp=%h cyc=33 tail=0",
                     res, cyc, tail, 32'd3);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] res;
        int           cyc;
        logic         tail;
        logic         saw_done;
        run_op(DIVU, 32'd1000, 32'd10, res, cyc, tail);
        checks++;
        if (res !== 32'd100) begin
            failures++;
            $display("FAIL flush_pre got=%h exp=%h", res, 32'd100);
        end
        bus.op_sel    = DIVU;
        bus.operand_a = 32'd50;
        bus.operand_b = 32'd5;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_calc_busy busy=%b exp=1", bus.busy);
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd100) begin
            failures++;
            $display("FAIL flush_abort busy=%b done=%b res=%h exp busy=0 done=0 res=%h",
                     bus.busy, bus.done, bus.result, 32'd100);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            saw_done |= bus.done | bus.busy;
            tick();
        end
        checks++;
        if (saw_done !== 1'b0 || bus.result !== 32'd100) begin
            failures++;
            $display("FAIL flush_quiet activity=%b res=%h exp activity=0 res=%h",
                     saw_done, bus.result, 32'd100);
        end
        run_op(DIVU, 32'd77, 32'd7, res, cyc, tail);
        checks++;
        if (res !== 32'd11 || cyc != 33 || tail !== 1'b0) begin
            failures++;
            $display("FAIL flush_after got=%h cyc=%0d tail=%b exp=%h cyc=33 tail=0",
                     res, cyc, tail, 32'd11);
        end
        // flush together with start in IDLE accepts nothing
        bus.op_sel    = DIV;
        bus.operand_a = 32'd5;
        bus.operand_b = 32'd0;
        bus.start     = 1'b1;
        bus.flush     = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd11) begin
            failures++;
            $display("FAIL flush_start busy=%b done=%b res=%h exp busy=0 done=0 res=%h",
                     bus.busy, bus.done, bus.result, 32'd11);
        end
    endtask

    task automatic test_reset_mid();
        bus.op_sel    = DIVU;
        bus.operand_a = 32'd100;
        bus.operand_b = 32'd7;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        rst_n         = 1'b0;
        bus.start     = 1'b1;
        bus.operand_a = 32'd5;
        bus.operand_b = 32'd0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid busy=%b done=%b res=%h exp busy=0 done=0 res=0",
                     bus.busy, bus.done, bus.result);
        end
        tick();
        rst_n     = 1'b1;
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
            failures++;
            $display("FAIL reset_start busy=%b done=%b res=%h exp busy=0 done=0 res=0",
                     bus.busy, bus.done, bus.result);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_ignore_busy();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter WIDTH, default 32, is the operand and result width in bits.
REQ-002 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  is the reset, synchronous and active-low.
REQ-004 start  input  1  is the request strobe, sampled only in IDLE.
REQ-005 flush  input  1  is the synchronous abort of any in-flight operation.
REQ-006 op_sel  input  2  selects the operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 operand_a  input  WIDTH  is the dividend, sampled with start.
REQ-008 operand_b  input  WIDTH  is the divisor, sampled with start.
REQ-009 busy  output  1  is high whenever state != IDLE.
REQ-010 done  output  1  is a one-cycle pulse marking result valid.
REQ-011 result  output  WIDTH  is the quotient or remainder; held until the next accepted start.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-013 IDLE + start=1 + flush=0 SHALL latch the operands and op_sel; all other input changes SHALL be ignored until the FSM returns to IDLE.
REQ-014 A divisor of 0 SHALL go IDLE->DONE and give quotient all-ones and remainder = dividend, for both signed and unsigned ops.
REQ-015 DIV/REM with dividend = most-negative and divisor = -1 SHALL go IDLE->DONE and give quotient = dividend and remainder 0.
REQ-016 All other accepted requests SHALL go IDLE->CALC with the iteration counter loaded to WIDTH-1.
REQ-017 Signed ops SHALL divide the absolute values; the quotient is negated when sign(a) XOR sign(b) is 1, and the remainder takes the sign of a.
REQ-018 Each CALC cycle SHALL perform one restoring step: shift in the next dividend MSB, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
REQ-019 CALC SHALL last exactly WIDTH cycles; the last step applies sign correction and goes to DONE.
REQ-020 DONE SHALL drive done=1 with a valid result for exactly one cycle, then go to IDLE.
REQ-021 Latency: start accepted at edge T gives done at cycle T+WIDTH+1 (normal case) or T+1 (REQ-014/015 cases).
REQ-022 start while busy=1, including during the DONE cycle, SHALL be ignored and not queued.
REQ-023 flush=1 SHALL force IDLE at the next edge from any state, with done=0 and result unchanged.
REQ-024 flush=1 together with start=1 in IDLE SHALL win: nothing is accepted.
REQ-025 Back-to-back: a start in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, result=0, counter=0, and all internal registers to 0, from any state including mid-CALC.
REQ-027 rst_n has priority over flush and start.
REQ-028 No asynchronous reset paths SHALL exist.

Structure
REQ-029 The shared RISC-V package SHALL hold the div_op_e enum (DIV, DIVU, REM, REMU encodings) and the div_state_e enum (IDLE, CALC, DONE).
REQ-030 The per-iteration combinational shift/trial-subtract MAY be a sub-module div_step (width-parameterized); the FSM, counter and sign logic stay in div_unit.
REQ-031 The block SHALL have no multiplier and no combinational path from inputs to done or result.

Verification
REQ-032 DIVU 100/7 started at T -> done=1 at T+33, result=14; REMU 100/7 -> result=2.
REQ-033 DIV 0xFFFFFFF9 (-7) / 2 -> result 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1).
REQ-034 DIV 5/0 -> result 0xFFFFFFFF at T+1; REMU 5/0 -> result 5 at T+1.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000 at T+1; REM -> 0.
REQ-036 flush=1 at T+10 of a DIVU -> busy=0 at T+11, no done pulse, result unchanged; a start at T+11 completes normally.
REQ-037 rst_n=0 at T+5 mid-CALC -> busy=0, done=0, result=0 after that edge; start held during reset is not accepted.
